// File: rtl/ysyx_23060136_exu_branch_resolve.sv
// EX-stage branch resolver: computes real direction/target for branch, jal and jalr,
// trains the IF-stage BHT, and raises a held redirect plus a one-cycle flush on mispredict.
module ysyx_23060136_exu_branch_resolve #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_is_branch,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pre_take,
  output logic [XLEN-1:0]  bht_pc,
  output logic             bht_pre_true,
  output logic             bht_pre_false,
  output logic             branch_pcsrc,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             dbg_state
);

  // Handshakes: an op transfers on a cycle with in_valid & in_ready & !stall_i;
  // a redirect transfers on a cycle with redirect_valid & redirect_ready & !stall_i.
  // Payloads on either side are held stable until their transfer cycle.

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic            sel_jalr;
  logic            sel_jal;
  logic            sel_br;
  logic            is_cf;
  logic            accept;
  logic            cond_taken;
  logic            taken;
  logic            mispred;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] jalr_sum;

  // Overlapping decode flags resolve as jalr > jal > branch.
  assign sel_jalr = in_is_jalr;
  assign sel_jal  = in_is_jal & ~in_is_jalr;
  assign sel_br   = in_is_branch & ~in_is_jal & ~in_is_jalr;
  assign is_cf    = sel_jalr | sel_jal | sel_br;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready & ~stall_i & is_cf;

  always_comb begin
    cond_taken = 1'b0;
    case (in_funct3)
      3'b000:  cond_taken = (in_rs1 == in_rs2);
      3'b001:  cond_taken = (in_rs1 != in_rs2);
      3'b100:  cond_taken = ($signed(in_rs1) <  $signed(in_rs2));
      3'b101:  cond_taken = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  cond_taken = (in_rs1 <  in_rs2);
      3'b111:  cond_taken = (in_rs1 >= in_rs2);
      default: cond_taken = 1'b0;
    endcase
  end

  assign taken    = sel_jalr | sel_jal | (sel_br & cond_taken);
  assign jalr_sum = in_rs1 + in_imm;
  assign target   = sel_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);
  assign seq_pc   = in_pc + XLEN'(4);
  assign next_pc  = taken ? target : seq_pc;

  // jalr is never predicted in IF, so it always needs a redirect.
  assign mispred  = sel_jalr | (taken != in_pre_take);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && mispred) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready && !stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign redirect_valid = (state_q == REDIRECT);
  assign dbg_state      = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bht_pc        <= '0;
      bht_pre_true  <= 1'b0;
      bht_pre_false <= 1'b0;
      branch_pcsrc  <= 1'b0;
      flush_o       <= 1'b0;
      redirect_pc   <= '0;
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
    end else if (!stall_i) begin
      if (accept) begin
        bht_pc        <= in_pc;
        bht_pre_true  <= sel_br & ~mispred;
        bht_pre_false <= sel_br & mispred;
        branch_pcsrc  <= taken;
        flush_o       <= mispred;
        if (mispred) redirect_pc <= next_pc;
        if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
        if (mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end else begin
        // Result pulses last exactly one unstalled cycle.
        bht_pre_true  <= 1'b0;
        bht_pre_false <= 1'b0;
        branch_pcsrc  <= 1'b0;
        flush_o       <= 1'b0;
      end
    end
  end

endmodule
